countdown_ctrl: RTL and testbench

- Control stage directly upstream of a two-digit down-counting BCD cascade (tens, ones; Direction = 0), used as the round timer.
- Loads the start time into the digits, generates the 1 Hz count pulse for the ones digit, pauses and resumes, and flags time-up when the display reads 00.
- Consumes the digit values fed back from the counters so that time-up is decided on what the player sees.

---
 rtl/countdown_ctrl_pkg.sv | 23 ++
 rtl/countdown_ctrl_tick_prescaler.sv | 39 +++
 rtl/countdown_ctrl.sv | 141 ++++++++++++++
 tb/tb_countdown_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the round timer: controller state encoding,
// BCD digit limit and the board-clock prescaler default.
package countdown_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      PAUSED = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // 1 Hz count pulse from the 50 MHz board clock
   localparam int TICK_DIV_DEFAULT = 50_000_000;

   // Out-of-range BCD digits are forced to the largest legal digit
   function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction

endpackage

// File: rtl/countdown_ctrl_tick_prescaler.sv
// Free-running cycle divider: counts 0..TickDiv-1 while enabled, holds
// its value while disabled, and flags the terminal count combinationally
// so the controller can register the resulting count pulse.
module tick_prescaler
   import countdown_ctrl_pkg::*;
#(
   parameter int TickDiv   = TICK_DIV_DEFAULT,
   parameter int TickWidth = 26
)
(
   input  logic CLK,
   input  logic RST,
   input  logic enable,
   input  logic clear,
   output logic tc
);

   localparam logic [TickWidth-1:0] LAST = TickWidth'(TickDiv - 1);

   logic [TickWidth-1:0] count_reg;

   assign tc = enable && (count_reg == LAST);

   // Divider register: clear wins, wraps at terminal count, holds when idle
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable) begin
         if (count_reg == LAST) begin
            count_reg <= '0;
         end else begin
            count_reg <= count_reg + TickWidth'(1);
         end
      end
   end

endmodule

// File: rtl/countdown_ctrl.sv
// Round-timer controller sitting in front of a two-digit down-counting
// BCD cascade. Loads the start time, paces the ones digit with a count
// pulse, handles pause/resume and raises TimeUp once the display reads 00.
module countdown_ctrl
   import countdown_ctrl_pkg::*;
#(
   parameter int TickDiv   = TICK_DIV_DEFAULT,
   parameter int TickWidth = 26
)
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       Start,
   input  logic       Pause,
   input  logic [3:0] LoadTens,
   input  logic [3:0] LoadOnes,
   input  logic [3:0] TensIn,
   input  logic [3:0] OnesIn,
   output logic       CountOut,
   output logic       SetOut,
   output logic [3:0] SetTens,
   output logic [3:0] SetOnes,
   output logic       Running,
   output logic       TimeUp
);

   state_t     state_reg, state_next;
   logic       start_q_reg, pause_q_reg;
   logic       count_out_reg, count_out_next;
   logic       set_out_reg, set_out_next;
   logic [3:0] set_tens_reg, set_tens_next;
   logic [3:0] set_ones_reg, set_ones_next;
   logic       running_reg, running_next;
   logic       time_up_reg, time_up_next;

   logic       start_edge, pause_edge;
   logic       prescale_en, tick;

   assign start_edge = Start && !start_q_reg;
   assign pause_edge = Pause && !pause_q_reg;

   // The prescaler already runs during LOAD so the first count pulse
   // lands exactly TickDiv cycles after the load strobe.
   assign prescale_en = (state_reg == LOAD) || (state_reg == RUN);

   tick_prescaler #(
      .TickDiv   (TickDiv),
      .TickWidth (TickWidth)
   ) u_prescaler (
      .CLK    (CLK),
      .RST    (RST),
      .enable (prescale_en),
      .clear  (start_edge),
      .tc     (tick)
   );

   // Next-state and next-output decode; Start overrides everything
   always_comb begin
      state_next     = state_reg;
      count_out_next = 1'b0;
      set_tens_next  = set_tens_reg;
      set_ones_next  = set_ones_reg;
      if (start_edge) begin
         state_next    = LOAD;
         set_tens_next = bcd_clamp(LoadTens);
         set_ones_next = bcd_clamp(LoadOnes);
      end else begin
         case (state_reg)
            LOAD: begin
               if ((set_tens_reg == 4'd0) && (set_ones_reg == 4'd0)) begin
                  state_next = DONE;
               end else begin
                  state_next = RUN;
               end
            end
            RUN: begin
               if (tick && (TensIn == 4'd0) && (OnesIn == 4'd0)) begin
                  // Display already at 00: stop instead of letting it wrap to 99
                  state_next = DONE;
               end else begin
                  count_out_next = tick;
                  if (pause_edge) begin
                     state_next = PAUSED;
                  end
               end
            end
            PAUSED: begin
               if (pause_edge) begin
                  state_next = RUN;
               end
            end
            default: begin
               state_next = state_reg;
            end
         endcase
      end
      set_out_next = (state_next == LOAD);
      running_next = (state_next == RUN);
      time_up_next = (state_next == DONE);
   end

   // State register and input edge-detect history
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg   <= IDLE;
         start_q_reg <= 1'b0;
         pause_q_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         start_q_reg <= Start;
         pause_q_reg <= Pause;
      end
   end

   // Registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count_out_reg <= 1'b0;
         set_out_reg   <= 1'b0;
         set_tens_reg  <= 4'd0;
         set_ones_reg  <= 4'd0;
         running_reg   <= 1'b0;
         time_up_reg   <= 1'b0;
      end else begin
         count_out_reg <= count_out_next;
         set_out_reg   <= set_out_next;
         set_tens_reg  <= set_tens_next;
         set_ones_reg  <= set_ones_next;
         running_reg   <= running_next;
         time_up_reg   <= time_up_next;
      end
   end

   assign CountOut = count_out_reg;
   assign SetOut   = set_out_reg;
   assign SetTens  = set_tens_reg;
   assign SetOnes  = set_ones_reg;
   assign Running  = running_reg;
   assign TimeUp   = time_up_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with TickDiv = 4 driving two down-counting
// BCD digits. A seconds-level reference model predicts load strobes,
// count pulses and time-up events into a queue; a monitor matches them
// against what the DUT presents, cycle by cycle.
module tb_countdown_ctrl;

   localparam int TICK_DIV = 4;
   localparam int K_SET    = 1;
   localparam int K_COUNT  = 2;
   localparam int K_TU     = 3;

   // model modes (reference model only)
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

   logic       CLK, RST, Start, Pause;
   logic [3:0] LoadTens, LoadOnes, TensIn, OnesIn;
   logic       CountOut, SetOut, Running, TimeUp;
   logic [3:0] SetTens, SetOnes;

   typedef struct {
      int kind;
      int cyc;
      int a;
      int b;
   } exp_t;

   exp_t q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // reference model state
   int m_mode = M_IDLE;
   int m_phase = 0;
   int m_rem = 0;
   int m_t = 0;
   int m_o = 0;
   bit m_sq = 0;
   bit m_pq = 0;
   bit exp_run = 0;
   bit exp_tu = 0;

   countdown_ctrl #(
      .TickDiv   (TICK_DIV),
      .TickWidth (2)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .Start    (Start),
      .Pause    (Pause),
      .LoadTens (LoadTens),
      .LoadOnes (LoadOnes),
      .TensIn   (TensIn),
      .OnesIn   (OnesIn),
      .CountOut (CountOut),
      .SetOut   (SetOut),
      .SetTens  (SetTens),
      .SetOnes  (SetOnes),
      .Running  (Running),
      .TimeUp   (TimeUp)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Two cascaded down-counting BCD digits; tens borrows only off CountOut
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         TensIn <= 4'd0;
         OnesIn <= 4'd0;
      end else if (SetOut) begin
         TensIn <= SetTens;
         OnesIn <= SetOnes;
      end else if (CountOut) begin
         if (OnesIn == 4'd0) begin
            OnesIn <= 4'd9;
            TensIn <= (TensIn == 4'd0) ? 4'd9 : TensIn - 4'd1;
         end else begin
            OnesIn <= OnesIn - 4'd1;
         end
      end
   end

   function automatic int clamp9(input int d);
      return (d > 9) ? 9 : d;
   endfunction

   function automatic exp_t mk(input int kind, input int c, input int a, input int b);
      exp_t e;
      e.kind = kind;
      e.cyc  = c;
      e.a    = a;
      e.b    = b;
      return e;
   endfunction

   // Reference model: remaining seconds plus cycles elapsed in the current second
   initial begin
      bit se, pe;
      forever begin
         @(posedge CLK or negedge RST);
         if (!RST) begin
            m_mode = M_IDLE; m_phase = 0; m_rem = 0;
            m_sq = 0; m_pq = 0; exp_run = 0; exp_tu = 0;
            q.delete();
         end else begin
            cyc++;
            se = Start && !m_sq;
            pe = Pause && !m_pq;
            m_sq = Start;
            m_pq = Pause;
            if (se) begin
               m_t = clamp9(int'(LoadTens));
               m_o = clamp9(int'(LoadOnes));
               m_mode = M_LOAD;
               m_phase = 0;
               q.push_back(mk(K_SET, cyc, m_t, m_o));
            end else begin
               case (m_mode)
                  M_LOAD: begin
                     m_rem = m_t * 10 + m_o;
                     m_phase = 1;
                     if (m_rem == 0) begin
                        m_mode = M_DONE;
                        q.push_back(mk(K_TU, cyc, 0, 0));
                     end else begin
                        m_mode = M_RUN;
                     end
                  end
                  M_RUN: begin
                     if (m_phase == TICK_DIV - 1) begin
                        m_phase = 0;
                        if (m_rem == 0) begin
                           m_mode = M_DONE;
                           q.push_back(mk(K_TU, cyc, 0, 0));
                        end else begin
                           q.push_back(mk(K_COUNT, cyc, m_rem, 0));
                           m_rem--;
                           if (pe) m_mode = M_PAUSED;
                        end
                     end else begin
                        m_phase++;
                        if (pe) m_mode = M_PAUSED;
                     end
                  end
                  M_PAUSED: begin
                     if (pe) m_mode = M_RUN;
                  end
                  default: ;
               endcase
            end
            exp_run = (m_mode == M_RUN);
            exp_tu  = (m_mode == M_DONE);
         end
      end
   end

   // Monitor: pop and compare whenever the DUT presents an event
   initial begin
      bit prev_tu;
      int dkind, ga, gb;
      exp_t e;
      prev_tu = 0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
               tests++; fails++;
               $display("FAIL missed_event kind=%0d expected at cyc=%0d, now cyc=%0d", q[0].kind, q[0].cyc, cyc);
               void'(q.pop_front());
            end
            dkind = 0; ga = 0; gb = 0;
            if (SetOut) begin
               dkind = K_SET; ga = int'(SetTens); gb = int'(SetOnes);
            end else if (CountOut) begin
               dkind = K_COUNT; ga = int'(TensIn) * 10 + int'(OnesIn);
            end else if (TimeUp && !prev_tu) begin
               dkind = K_TU; ga = int'(TensIn) * 10 + int'(OnesIn);
            end
            if (SetOut && CountOut) begin
               tests++; fails++;
               $display("FAIL set_and_count cyc=%0d both high", cyc);
            end
            if (dkind != 0 || (q.size() > 0 && q[0].cyc == cyc)) begin
               tests++;
               if (q.size() == 0 || q[0].cyc != cyc) begin
                  fails++;
                  $display("FAIL unexpected_event cyc=%0d got kind=%0d a=%0d b=%0d, required none", cyc, dkind, ga, gb);
               end else begin
                  e = q.pop_front();
                  if (e.kind != dkind || e.a != ga || e.b != gb) begin
                     fails++;
                     $display("FAIL event cyc=%0d got kind=%0d a=%0d b=%0d, required kind=%0d a=%0d b=%0d",
                              cyc, dkind, ga, gb, e.kind, e.a, e.b);
                  end else begin
                     $display("[TB] cyc=%0d event kind=%0d a=%0d b=%0d ok", cyc, dkind, ga, gb);
                  end
               end
            end
            tests++;
            if (Running !== exp_run) begin
               fails++;
               $display("FAIL running cyc=%0d got %b, required %b", cyc, Running, exp_run);
            end
            tests++;
            if (TimeUp !== exp_tu) begin
               fails++;
               $display("FAIL timeup cyc=%0d got %b, required %b", cyc, TimeUp, exp_tu);
            end
         end
         prev_tu = TimeUp;
      end
   end

   task automatic check_all_zero(input string tag);
      tests++;
      if ({CountOut, SetOut, SetTens, SetOnes, Running, TimeUp} !== 12'd0) begin
         fails++;
         $display("FAIL %s outputs=%h, required 000", tag,
                  {CountOut, SetOut, SetTens, SetOnes, Running, TimeUp});
      end else begin
         $display("[TB] %s outputs all zero", tag);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Raise the selected inputs for w cycles, then drop them for one cycle
   task automatic pulse(input bit s, input bit p, input int w);
      if (s) Start = 1'b1;
      if (p) Pause = 1'b1;
      idle(w);
      Start = 1'b0;
      Pause = 1'b0;
      idle(1);
   endtask

   task automatic start_with(input int t, input int o);
      LoadTens = 4'(t);
      LoadOnes = 4'(o);
      pulse(1'b1, 1'b0, 1);
   endtask

   initial begin
      int k;
      RST = 1'b0; Start = 1'b0; Pause = 1'b0;
      LoadTens = 4'd0; LoadOnes = 4'd0;
      idle(3);
      check_all_zero("reset_state");
      RST = 1'b1;
      idle(5);

      // 03 counts down to 00, then time-up without a fourth pulse
      start_with(0, 3);
      idle(25);

      // 10 -> 09 -> 08 borrow across digits
      start_with(1, 0);
      idle(12);

      // pause two cycles after a count pulse, hold, resume
      start_with(0, 5);
      k = 0;
      while (!CountOut && k < 20) begin idle(1); k++; end
      tests++;
      if (k >= 20) begin
         fails++;
         $display("FAIL wait_countout no pulse within 20 cycles");
      end
      idle(2);
      pulse(1'b0, 1'b1, 1);
      idle(10);
      pulse(1'b0, 1'b1, 1);
      idle(30);

      // 00 goes straight to time-up; out-of-range digits clamp to 99
      start_with(0, 0);
      idle(6);
      start_with(15, 12);
      idle(9);

      // Start and Pause together mid-run, then Start held for 20 cycles
      LoadTens = 4'd0; LoadOnes = 4'd7;
      pulse(1'b1, 1'b1, 1);
      idle(6);
      pulse(1'b1, 1'b0, 20);
      idle(8);

      // asynchronous reset mid-run, away from a clock edge
      start_with(0, 9);
      idle(9);
      #2 RST = 1'b0;
      #1 check_all_zero("async_reset");
      idle(3);
      RST = 1'b1;
      idle(12);

      // randomized sequences of loads, pauses and idle gaps
      for (int i = 0; i < 60; i++) begin
         int act;
         act = int'($urandom_range(0, 4));
         case (act)
            0, 1: begin
               LoadTens = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
               LoadOnes = 4'($urandom_range(0, 15));
               pulse(1'b1, 1'b0, int'($urandom_range(1, 3)));
            end
            2: pulse(1'b0, 1'b1, int'($urandom_range(1, 3)));
            3: pulse(1'b1, 1'b1, int'($urandom_range(1, 2)));
            default: ;
         endcase
         idle(int'($urandom_range(1, 40)));
      end

      idle(5);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL pending_events %0d left, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
